addsub_serial_ctrl: RTL and testbench
=====================================

# addsub_serial_ctrl

Bit-serial add/subtract controller. It drives one 1-bit add/sub cell over WIDTH clock cycles to produce a WIDTH-bit sum or difference. Operands are latched on a start handshake and shifted LSB-first through the cell, with the carry held in a flip-flop between bits. Results, carry-out and signed overflow are reported with a one-cycle done pulse. It sits between the datapath register file and the shared serial ALU cell, trading latency for area.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥2)

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when ready (IDLE or DONE)
- op  input  1  0 = add (a+b), 1 = subtract (a−b); latched with start
- a  input  WIDTH  operand A; latched with start
- b  input  WIDTH  operand B; latched with start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse, result valid
- result  output  WIDTH  sum/difference, held until next accepted start
- cout  output  1  final carry (sub: 1 = no borrow, i.e. a ≥ b unsigned)
- ovf  output  1  two's-complement overflow

## Operation
- FSM states are IDLE, SHIFT and DONE.
- IDLE → SHIFT on start=1:
  - load sa←a, sb←b, op_r←op, bitcnt←0, carry←op.
  - Subtract therefore uses carry-in 1 with inverted b bits.
- SHIFT, each cycle:
  - Cell inputs: sa[0], sb[0]^op_r, carry.
  - Cell sum shifts into result MSB (result ← {sum, result[WIDTH-1:1]}).
  - sa, sb shift right; carry ← cell cout; bitcnt++.
  - On bitcnt == WIDTH−1, record ovf ← carry_in_of_this_bit ^ cell_cout, cout ← cell_cout, then go to DONE.
- DONE: done=1 for exactly this cycle.
  - start=1 here is accepted exactly as in IDLE (back-to-back operation) → SHIFT.
  - Otherwise → IDLE.
- start during SHIFT is ignored; operands are not re-latched.
- result, cout and ovf change only during SHIFT. They remain stable in DONE and in IDLE afterwards.
- Width rules:
  - result wraps modulo 2^WIDTH.
  - bitcnt is $clog2(WIDTH) bits wide.
  - No sign extension.

## Timing
- Reset (sync, any state including mid-SHIFT): state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0, carry=0, bitcnt=0. Any operation in flight is aborted with no done pulse.
- Latency: start sampled at edge E0 → busy=1 for cycles after E0 through E_WIDTH → done=1 in the cycle after edge E_WIDTH (i.e. WIDTH+1 cycles after start accepted).
- Throughput: one operation per WIDTH+1 cycles with back-to-back starts issued in DONE.
- busy and done are never high together.
- rst and start in the same cycle: rst wins.
- Cell delay must settle within one clock period. The cell's combinational path is the only path from the shift registers to carry.

## Structure
- Shared package/header (`addsub_pkg`/include):
  - FSM state encodings S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2.
  - OP_ADD=1'b0, OP_SUB=1'b1.
- One sub-module: the team's 1-bit add/sub cell `addsub` (out, cout, a, b, cin, selec). Its select input is driven by op_r.
- The controller itself holds only registers and the FSM. Inversion of b is done in the cell, not duplicated in the controller.

## Test plan
- WIDTH=8, add 25+17 → result=42, cout=0, ovf=0; done exactly 9 cycles after the start edge; busy high 8 cycles.
- Add 100+100 → result=0xC8, cout=0, ovf=1; add 0xFF+0x01 → result=0x00, cout=1, ovf=0.
- Sub 5−9 → result=0xFC, cout=0, ovf=0; sub 0x80−0x01 → result=0x7F, cout=1, ovf=1.
- start pulsed with new operands at SHIFT cycle 3 → ignored; original result delivered on schedule, no second done.
- rst asserted at SHIFT cycle 4 → next cycle IDLE, all outputs 0, no done. A new start then completes 30−7=23 normally.
- start held high continuously (A=3,B=4 add, then A=10,B=1 sub) → done pulses every 9 cycles; results 7 then 9; busy low only in DONE cycles.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract controller and its cell.
// State and opcode encodings are fixed so other blocks can decode them.
package addsub_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Signed overflow: carry into the MSB differs from carry out of the MSB.
  function automatic logic signed_ovf(input logic cin_msb, input logic cout_msb);
    return cin_msb ^ cout_msb;
  endfunction

endpackage

// File: rtl/addsub.sv
// One-bit add/subtract cell shared with the serial ALU.
// selec=1 inverts b, so subtraction is a + ~b + cin with cin driven to 1 by the caller.
module addsub
  import addsub_pkg::*;
(
  output logic out,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic selec
);

  logic b_eff_s;

  // Full-adder with optional inversion of b.
  always_comb begin
    b_eff_s = b ^ (selec == OP_SUB);
    out     = a ^ b_eff_s ^ cin;
    cout    = (a & b_eff_s) | (a & cin) | (b_eff_s & cin);
  end

endmodule

// File: rtl/addsub_serial_ctrl.sv
// Bit-serial add/subtract controller: latches operands on start and walks them
// LSB-first through one addsub cell, reporting result, carry-out and overflow.
module addsub_serial_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] sa_q,     sa_d;
  logic [WIDTH-1:0] sb_q,     sb_d;
  logic             op_q,     op_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic             carry_q,  carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic cell_sum_s;
  logic cell_cout_s;

  addsub u_cell (
    .out   (cell_sum_s),
    .cout  (cell_cout_s),
    .a     (sa_q[0]),
    .b     (sb_q[0]),
    .cin   (carry_q),
    .selec (op_q)
  );

  // Next-state and datapath update for the serial FSM.
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    op_d     = op_q;
    bitcnt_d = bitcnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_SHIFT;
          sa_d     = a;
          sb_d     = b;
          op_d     = op;
          bitcnt_d = '0;
          carry_d  = op;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_SHIFT: begin
        result_d = {cell_sum_s, result_q[WIDTH-1:1]};
        sa_d     = {1'b0, sa_q[WIDTH-1:1]};
        sb_d     = {1'b0, sb_q[WIDTH-1:1]};
        carry_d  = cell_cout_s;
        bitcnt_d = bitcnt_q + CW'(1);
        if (bitcnt_q == LAST) begin
          ovf_d   = signed_ovf(carry_q, cell_cout_s);
          cout_d  = cell_cout_s;
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      op_q     <= 1'b0;
      bitcnt_q <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      op_q     <= op_d;
      bitcnt_q <= bitcnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_addsub_serial_ctrl.sv
// Directed plus randomized checks of addsub_serial_ctrl against an arithmetic model.
module tb_addsub_serial_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, op;
  logic [W-1:0] a, b, result;
  logic         busy, done, cout, ovf;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  addsub_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic o,
                       output logic [W-1:0] r, output logic c, output logic v);
    int sx, sy, ideal;
    sx = int'($signed(x));
    sy = int'($signed(y));
    ideal = o ? (sx - sy) : (sx + sy);
    v = (ideal < -(1 << (W-1))) || (ideal > (1 << (W-1)) - 1);
    r = o ? W'(x - y) : W'(x + y);
    c = o ? (x >= y) : ((int'(x) + int'(y)) > (1 << W) - 1);
  endtask

  // One operation; inj_k>0 pulses start with other operands in that SHIFT cycle.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic o,
                        input string tag, input int inj_k);
    logic [W-1:0] er, res_at_done;
    logic ec, ev;
    int busy_cnt, done_cnt, done_at, both_cnt;
    model(x, y, o, er, ec, ev);
    @(negedge clk);
    start = 1'b1; a = x; b = y; op = o;
    busy_cnt = 0; done_cnt = 0; done_at = 0; both_cnt = 0; res_at_done = '0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == inj_k) begin
        start = 1'b1; a = ~x; b = x; op = ~o;
      end else begin
        start = 1'b0; a = W'($urandom); b = W'($urandom); op = 1'($urandom);
      end
      if (busy) busy_cnt++;
      if (busy && done) both_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = k;
          res_at_done = result;
        end
      end
    end
    chk({tag, " done_at"},   done_at, 9);
    chk({tag, " done_cnt"},  done_cnt, 1);
    chk({tag, " busy_cnt"},  busy_cnt, 8);
    chk({tag, " busy&done"}, both_cnt, 0);
    chk({tag, " res@done"},  res_at_done, er);
    chk({tag, " result"},    result, er);
    chk({tag, " cout"},      cout, ec);
    chk({tag, " ovf"},       ovf, ev);
  endtask

  initial begin
    int dk [2];
    logic [W-1:0] dres [2];
    int nd, bad, cnt;

    rst = 1'b1; start = 1'b1; op = 1'b0; a = 8'd3; b = 8'd4;
    repeat (3) @(negedge clk);
    chk("rst busy",   busy, 0);
    chk("rst done",   done, 0);
    chk("rst result", result, 0);
    chk("rst cout",   cout, 0);
    chk("rst ovf",    ovf, 0);
    rst = 1'b0; start = 1'b0;

    run_op(8'd25,  8'd17,  1'b0, "add25_17", 0);
    run_op(8'd100, 8'd100, 1'b0, "add100_100", 0);
    run_op(8'hFF,  8'h01,  1'b0, "addFF_01", 0);
    run_op(8'd5,   8'd9,   1'b1, "sub5_9", 0);
    run_op(8'h80,  8'h01,  1'b1, "sub80_01", 0);
    chk("sub80 literal result", result, 8'h7F);

    run_op(8'h3C, 8'h21, 1'b0, "start_ignored", 3);

    // Re-establish cout=ovf=1 so the mid-SHIFT reset has visible state to clear.
    run_op(8'h80, 8'h01, 1'b1, "pre_rst", 0);
    @(negedge clk);
    start = 1'b1; a = 8'd55; b = 8'd66; op = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst busy",   busy, 0);
    chk("midrst done",   done, 0);
    chk("midrst result", result, 0);
    chk("midrst cout",   cout, 0);
    chk("midrst ovf",    ovf, 0);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("midrst quiet", cnt, 0);
    run_op(8'd30, 8'd7, 1'b1, "sub30_7", 0);

    // Back-to-back with start held high.
    @(negedge clk);
    start = 1'b1; a = 8'd3; b = 8'd4; op = 1'b0;
    nd = 0; bad = 0; cnt = 0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (busy) cnt++;
      if (k <= 18 && busy === done) bad++;
      if (done) begin
        if (nd < 2) begin
          dk[nd] = k;
          dres[nd] = result;
        end
        nd++;
      end
      if (k == 9) begin
        a = 8'd10; b = 8'd1; op = 1'b1;
      end
      if (k == 18) start = 1'b0;
    end
    chk("b2b done count", nd, 2);
    chk("b2b done1 at",   dk[0], 9);
    chk("b2b done2 at",   dk[1], 18);
    chk("b2b result1",    dres[0], 8'd7);
    chk("b2b result2",    dres[1], 8'd9);
    chk("b2b busy!=done", bad, 0);
    chk("b2b busy cycles", cnt, 16);

    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rand%0d", i), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
